// File: rtl/apb_wait_slave_pkg.sv
// apb_wait_slave_pkg: shared state encoding, data width and address-legality check for apb_wait_slave
package apb_wait_slave_pkg;
  localparam int APB_DW = 32;
  typedef enum logic {ST_IDLE = 1'b0, ST_ACCESS = 1'b1} state_t;
  function automatic logic addr_legal(input logic [63:0] addr, input int depth);
    return addr[1:0] == 2'b00 && addr < 64'(depth) * 64'd4;
  endfunction
endpackage

// File: rtl/apb_wait_counter.sv
// apb_wait_counter: loadable down-counter with zero flag, stops at zero
module apb_wait_counter #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic         zero
);
  logic [W-1:0] cnt;
  always_ff @(posedge clk) begin
    if (rst) cnt <= '0;
    else if (load) cnt <= load_val;
    else if (dec && cnt != '0) cnt <= cnt - 1'b1;
  end
  assign zero = cnt == '0;
endmodule

// File: rtl/apb_wait_slave.sv
// apb_wait_slave: APB3 completer with DEPTH x 32-bit registers, WAIT_CYCLES wait states and PSLVERR.
// Define APB_PSTRB_EN to add the PSTRB byte-strobe input.
module apb_wait_slave
  import apb_wait_slave_pkg::*;
#(
  parameter int DEPTH       = 16,
  parameter int WAIT_CYCLES = 2,
  parameter int ADDR_W      = 32
) (
  input  logic              PCLK,
  input  logic              PRESET,
  input  logic              PSEL,
  input  logic              PENABLE,
  input  logic              PWRITE,
  input  logic [ADDR_W-1:0] PADDR,
  input  logic [APB_DW-1:0] PWDATA,
`ifdef APB_PSTRB_EN
  input  logic [3:0]        PSTRB,
`endif
  output logic [APB_DW-1:0] PRDATA,
  output logic              PREADY,
  output logic              PSLVERR
);
  localparam int IW = $clog2(DEPTH);
  state_t state, state_nx;
  logic [APB_DW-1:0] regs [DEPTH];
  logic [APB_DW-1:0] wval;
  logic [IW-1:0] idx;
  logic legal, load, zero;
  assign idx   = PADDR[IW+1:2];
  assign legal = addr_legal(64'(PADDR), DEPTH);
  assign load  = state == ST_IDLE && PSEL && !PENABLE;
  apb_wait_counter #(.W(4)) u_cnt (
    .clk(PCLK),
    .rst(PRESET),
    .load(load),
    .load_val(4'(WAIT_CYCLES)),
    .dec(state == ST_ACCESS && PSEL && PENABLE),
    .zero(zero)
  );
  always_ff @(posedge PCLK) begin
    if (PRESET) state <= ST_IDLE;
    else state <= state_nx;
  end
  always_comb begin
    PREADY   = state == ST_ACCESS && PSEL && PENABLE && zero;
    state_nx = (state == ST_IDLE) ? (load ? ST_ACCESS : ST_IDLE)
                                  : ((!PSEL || PREADY) ? ST_IDLE : ST_ACCESS);
    PSLVERR  = PREADY && !legal;
    PRDATA   = (PREADY && !PWRITE && legal) ? regs[idx] : '0;
  end
  always_comb begin
    wval = PWDATA;
`ifdef APB_PSTRB_EN
    for (int i = 0; i < 4; i++) wval[8*i+:8] = PSTRB[i] ? PWDATA[8*i+:8] : regs[idx][8*i+:8];
`endif
  end
  // legality is taken from the completing cycle's address, not the setup one
  always_ff @(posedge PCLK) begin
    if (PRESET) for (int i = 0; i < DEPTH; i++) regs[i] <= '0;
    else if (PREADY && PWRITE && legal) regs[idx] <= wval;
  end
endmodule

// File: tb/tb_apb_wait_slave.sv
// tb_apb_wait_slave: directed bench for apb_wait_slave, WAIT_CYCLES=2 on bus 0 and WAIT_CYCLES=0 on bus 1.
module tb_apb_wait_slave;
  logic clk = 0;
  always #5 clk = ~clk;
  logic rst [2], psel [2], pen [2], pw [2];
  logic [31:0] paddr [2], pwdata [2], prdata [2];
  logic [3:0] pstrb [2];
  logic pready [2], pslverr [2];
  logic e_ready [2], e_err [2];
  logic [31:0] e_rdata [2];
  logic [31:0] m [2][16];
  logic en = 0;
  int checks = 0, errors = 0;
  logic [31:0] rd;
  logic err;
  int lat;

  apb_wait_slave #(.DEPTH(16), .WAIT_CYCLES(2), .ADDR_W(32)) d0 (
    .PCLK(clk), .PRESET(rst[0]), .PSEL(psel[0]), .PENABLE(pen[0]), .PWRITE(pw[0]),
    .PADDR(paddr[0]), .PWDATA(pwdata[0]),
`ifdef APB_PSTRB_EN
    .PSTRB(pstrb[0]),
`endif
    .PRDATA(prdata[0]), .PREADY(pready[0]), .PSLVERR(pslverr[0]));
  apb_wait_slave #(.DEPTH(16), .WAIT_CYCLES(0), .ADDR_W(32)) d1 (
    .PCLK(clk), .PRESET(rst[1]), .PSEL(psel[1]), .PENABLE(pen[1]), .PWRITE(pw[1]),
    .PADDR(paddr[1]), .PWDATA(pwdata[1]),
`ifdef APB_PSTRB_EN
    .PSTRB(pstrb[1]),
`endif
    .PRDATA(prdata[1]), .PREADY(pready[1]), .PSLVERR(pslverr[1]));

  // every cycle the outputs must equal the bench's protocol model
  always @(negedge clk) begin
    if (en) for (int b = 0; b < 2; b++) begin
      checks++;
      if ({pready[b], pslverr[b], prdata[b]} !== {e_ready[b], e_err[b], e_rdata[b]}) begin
        errors++;
        $display("FAIL cycle bus%0d t=%0t got rdy=%b err=%b rd=%h want rdy=%b err=%b rd=%h",
                 b, $time, pready[b], pslverr[b], prdata[b], e_ready[b], e_err[b], e_rdata[b]);
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got %h want %h", name, got, want);
    end
  endtask

  task automatic clr_exp(input int b);
    e_ready[b] = 0; e_err[b] = 0; e_rdata[b] = 0;
  endtask

  task automatic clr_mem(input int b);
    for (int i = 0; i < 16; i++) m[b][i] = 0;
  endtask

  task automatic idle(input int b);
    @(posedge clk); #1;
    psel[b] = 0; pen[b] = 0; clr_exp(b);
  endtask

  task automatic xfer(input int b, input bit wr, input logic [31:0] a, input logic [31:0] d,
                      input logic [3:0] s, input int abort_k, input int rst_k,
                      output logic [31:0] r, output logic e, output int l);
    int w;
    bit legal;
    w = (b == 0) ? 2 : 0;
    legal = a[1:0] == 2'b00 && a < 64;
    r = 0; e = 0; l = 0;
    @(posedge clk); #1;
    psel[b] = 1; pen[b] = 0; pw[b] = wr; paddr[b] = a; pwdata[b] = d; pstrb[b] = s; clr_exp(b);
    for (int k = 0; k <= w; k++) begin
      @(posedge clk); #1;
      if (k == abort_k) begin
        psel[b] = 0; pen[b] = 0; clr_exp(b);
        return;
      end
      pen[b] = 1;
      if (k == rst_k) begin
        rst[b] = 1; clr_exp(b);
        @(posedge clk); #1;
        clr_mem(b); psel[b] = 0; pen[b] = 0;
        @(posedge clk); #1;
        rst[b] = 0;
        return;
      end
      e_ready[b] = k == w;
      e_err[b] = (k == w) && !legal;
      e_rdata[b] = (k == w && !wr && legal) ? m[b][a[5:2]] : 32'h0;
      @(negedge clk);
      if (pready[b] && l == 0) begin l = k + 1; r = prdata[b]; e = pslverr[b]; end
    end
    if (wr && legal) for (int i = 0; i < 4; i++)
      if (s[i]) m[b][a[5:2]][8*i+:8] = d[8*i+:8];
  endtask

  initial begin
    for (int b = 0; b < 2; b++) begin
      rst[b] = 1; psel[b] = 0; pen[b] = 0; pw[b] = 0; paddr[b] = 0; pwdata[b] = 0; pstrb[b] = 4'hF;
      clr_exp(b); clr_mem(b);
    end
    @(posedge clk); #1 en = 1;
    @(posedge clk); #1 rst[0] = 0; rst[1] = 0;
    xfer(0, 0, 32'h04, 0, 4'hF, -1, -1, rd, err, lat); idle(0);
    chk("rst_read_data", rd, 32'h0); chk("rst_read_err", 32'(err), 0); chk("rst_read_lat", lat, 3);
    xfer(0, 1, 32'h00, 32'h0000_1234, 4'hF, -1, -1, rd, err, lat); idle(0);
    chk("wr0_lat", lat, 3);
    xfer(0, 0, 32'h00, 0, 4'hF, -1, -1, rd, err, lat); idle(0);
    chk("rd0_data", rd, 32'h0000_1234); chk("rd0_lat", lat, 3);
    xfer(0, 1, 32'h40, 32'hDEAD_BEEF, 4'hF, -1, -1, rd, err, lat); idle(0);
    chk("wr40_err", 32'(err), 1);
    xfer(0, 0, 32'h02, 0, 4'hF, -1, -1, rd, err, lat); idle(0);
    chk("rd02_err", 32'(err), 1); chk("rd02_data", rd, 32'h0);
    xfer(0, 0, 32'h00, 0, 4'hF, -1, -1, rd, err, lat); idle(0);
    chk("rd0_after_bad", rd, 32'h0000_1234);
    xfer(0, 1, 32'h3C, 32'hCAFE_0001, 4'hF, -1, -1, rd, err, lat); idle(0);
    xfer(0, 0, 32'h3C, 0, 4'hF, -1, -1, rd, err, lat); idle(0);
    chk("rd3c_top", rd, 32'hCAFE_0001); chk("rd3c_err", 32'(err), 0);
    xfer(1, 1, 32'h08, 32'hAAAA_0008, 4'hF, -1, -1, rd, err, lat);
    chk("b2b_wr08_lat", lat, 1);
    xfer(1, 1, 32'h0C, 32'hBBBB_000C, 4'hF, -1, -1, rd, err, lat);
    chk("b2b_wr0c_lat", lat, 1);
    xfer(1, 0, 32'h08, 0, 4'hF, -1, -1, rd, err, lat);
    chk("b2b_rd08", rd, 32'hAAAA_0008);
    xfer(1, 0, 32'h0C, 0, 4'hF, -1, -1, rd, err, lat); idle(1);
    chk("b2b_rd0c", rd, 32'hBBBB_000C); chk("b2b_rd0c_lat", lat, 1);
    xfer(0, 1, 32'h10, 32'h0000_0055, 4'hF, -1, -1, rd, err, lat); idle(0);
    xfer(0, 1, 32'h10, 32'h9999_9999, 4'hF, 1, -1, rd, err, lat); idle(0);
    xfer(0, 0, 32'h10, 0, 4'hF, -1, -1, rd, err, lat); idle(0);
    chk("abort_keeps", rd, 32'h0000_0055);
    @(posedge clk); #1 psel[0] = 1; pen[0] = 1; clr_exp(0);
    @(posedge clk); #1;
    idle(0);
    xfer(0, 1, 32'h1C, 32'h7777_7777, 4'hF, -1, 1, rd, err, lat); idle(0);
    xfer(0, 0, 32'h1C, 0, 4'hF, -1, -1, rd, err, lat); idle(0);
    chk("midrst_nowrite", rd, 32'h0);
    xfer(0, 0, 32'h00, 0, 4'hF, -1, -1, rd, err, lat); idle(0);
    chk("midrst_cleared", rd, 32'h0);
`ifdef APB_PSTRB_EN
    xfer(0, 1, 32'h14, 32'hFFFF_FFFF, 4'hF, -1, -1, rd, err, lat); idle(0);
    xfer(0, 1, 32'h14, 32'h1122_3344, 4'b0101, -1, -1, rd, err, lat); idle(0);
    xfer(0, 0, 32'h14, 0, 4'h0, -1, -1, rd, err, lat); idle(0);
    chk("strb_0101", rd, 32'hFF22_FF44);
    xfer(0, 1, 32'h14, 32'h0, 4'h0, -1, -1, rd, err, lat); idle(0);
    chk("strb_0000_lat", lat, 3);
    xfer(0, 0, 32'h14, 0, 4'hF, -1, -1, rd, err, lat); idle(0);
    chk("strb_0000_keep", rd, 32'hFF22_FF44);
`endif
    repeat (2) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
